// File: rtl/spi_master.sv
// spi_master: single-clock SPI master, runtime CPOL/CPHA and frame length
// SCLK comes from a clock-enable divider; every output is registered

module spi_master #(
  parameter int SIZE     = 40,
  parameter int CS_SIZE  = 1,
  parameter int CLK_SIZE = 8,
  localparam int LEN_W   = $clog2(SIZE + 1),
  localparam int SEL_W   = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1,
  localparam int EDGE_W  = $clog2(2 * SIZE + 1)
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                start_in,
  output logic                ready_out,
  output logic                done_out,
  input  logic [SIZE-1:0]     data_in,
  input  logic [LEN_W-1:0]    len_in,
  input  logic [CLK_SIZE-1:0] clk_count_max,
  input  logic                cpol_in,
  input  logic                cpha_in,
  input  logic [SEL_W-1:0]    cs_select_in,
  input  logic                serial_in,
  output logic                serial_out,
  output logic                clk_out,
  output logic [CS_SIZE-1:0]  cs_out_n,
  output logic [SIZE-1:0]     data_out
);

  typedef enum logic [2:0] {
    IDLE, LEAD, XFER, TRAIL, GAP
  } state_t;

  state_t              state_q, state_d;
  logic [CLK_SIZE-1:0] div_q, max_q;
  logic                cpol_q, cpha_q;
  logic [LEN_W-1:0]    len_q, len_eff;
  logic [EDGE_W-1:0]   edge_q, edge_nxt;
  logic [SIZE-1:0]     tx_q, rx_q, tx_load;
  logic [CS_SIZE-1:0]  cs_dec;
  logic                tick, accept, last_edge;

  assign tick = (state_q != IDLE) && (div_q == max_q);
  assign accept = (state_q == IDLE) && start_in && ready_out;
  assign edge_nxt = edge_q + EDGE_W'(1);
  assign last_edge = edge_nxt == EDGE_W'({len_q, 1'b0});

  assign len_eff =
    (len_in == '0 || len_in > LEN_W'(SIZE)) ? LEN_W'(SIZE) : len_in;
  // left-align so bit len-1 sits in the MSB of the shifter
  assign tx_load = data_in << (LEN_W'(SIZE) - len_eff);

  // one-hot active-low select; out-of-range index selects nobody
  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < CS_SIZE; i++)
      if (int'(cs_select_in) == i) cs_dec[i] = 1'b0;
  end

  // state register
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next-state: every busy state but XFER lasts one half-period
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = LEAD;
      LEAD:  if (tick) state_d = XFER;
      XFER:  if (tick && last_edge) state_d = TRAIL;
      TRAIL: if (tick) state_d = GAP;
      GAP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // divider, shifters and registered outputs
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      div_q      <= '0;
      max_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      len_q      <= '0;
      edge_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      ready_out  <= 1'b1;
      done_out   <= 1'b0;
      serial_out <= 1'b0;
      clk_out    <= 1'b0;
      cs_out_n   <= '1;
      data_out   <= '0;
    end else begin
      done_out <= 1'b0;
      if (state_q == IDLE || tick) div_q <= '0;
      else div_q <= div_q + CLK_SIZE'(1);
      unique case (state_q)
        IDLE: begin
          clk_out <= cpol_in;
          if (accept) begin
            max_q     <= clk_count_max;
            cpol_q    <= cpol_in;
            cpha_q    <= cpha_in;
            len_q     <= len_eff;
            edge_q    <= '0;
            rx_q      <= '0;
            ready_out <= 1'b0;
            cs_out_n  <= cs_dec;
            if (!cpha_in) begin
              serial_out <= tx_load[SIZE-1];
              tx_q       <= tx_load << 1;
            end else begin
              tx_q <= tx_load;
            end
          end
        end
        XFER: if (tick) begin
          clk_out <= ~clk_out;
          edge_q  <= edge_nxt;
          // odd edges lead; CPHA picks which kind samples
          if (edge_nxt[0] ^ cpha_q) begin
            rx_q <= (rx_q << 1) | SIZE'(serial_in);
          end else if (!last_edge) begin
            serial_out <= tx_q[SIZE-1];
            tx_q       <= tx_q << 1;
          end
        end
        TRAIL: if (tick) begin
          clk_out  <= cpol_q;
          cs_out_n <= '1;
          data_out <= rx_q;
          done_out <= 1'b1;
        end
        GAP: if (tick) begin
          ready_out <= 1'b1;
          edge_q    <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed frames against spi_master
// loopback or small SPI slave on MISO, counters watch SCLK/CS/done

module tb_spi_master;

  localparam int SIZE = 8;
  localparam int CS_SIZE = 5;
  localparam int CLK_SIZE = 8;

  logic clk = 0, rst_n = 0, start = 0;
  logic ready, done, miso, mosi, sclk;
  logic [7:0] din = 0, cmax = 0, dout;
  logic [3:0] len = 0;
  logic cpol = 0, cpha = 0;
  logic [2:0] sel = 0;
  logic [4:0] cs_n;

  logic loop = 1, s_miso = 0, cs_act;
  logic [7:0] reply = 8'h3C, s_rx = 0;
  int sidx = 7;

  int total = 0, bad = 0;
  int edges = 0, dones = 0, cs_low = 0, cyc = 0;
  int last_tog = 0, hp_min = 0, hp_max = 0, hp_d = 0;
  int n = 0, w = 0;
  bit hp_have = 0;
  logic sclk_prev = 0;
  logic [4:0] cs_acc = '1;

  spi_master #(
    .SIZE(SIZE), .CS_SIZE(CS_SIZE), .CLK_SIZE(CLK_SIZE)
  ) dut (
    .clk_in(clk),
    .reset_n_in(rst_n),
    .start_in(start),
    .ready_out(ready),
    .done_out(done),
    .data_in(din),
    .len_in(len),
    .clk_count_max(cmax),
    .cpol_in(cpol),
    .cpha_in(cpha),
    .cs_select_in(sel),
    .serial_in(miso),
    .serial_out(mosi),
    .clk_out(sclk),
    .cs_out_n(cs_n),
    .data_out(dout)
  );

  assign miso = loop ? mosi : s_miso;
  assign cs_act = ~&cs_n;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: no finish, bad=%0d", bad);
    $fatal(1);
  end

  // slave: load first bit when selected
  always @(posedge cs_act) begin
    s_rx = 0;
    sidx = 7;
    if (!cpha) begin
      #1;
      s_miso = reply[7];
    end
  end

  // slave: sample MOSI / shift MISO on SCLK edges
  always @(sclk) begin
    if (cs_act === 1'b1) begin
      if (((sclk != cpol) ^ cpha) == 1'b1) begin
        s_rx = {s_rx[6:0], mosi};
      end else if (cpha) begin
        #1;
        s_miso = reply[sidx];
        sidx--;
      end else begin
        sidx--;
        if (sidx >= 0) begin
          #1;
          s_miso = reply[sidx];
        end
      end
    end
  end

  // monitor sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sclk !== sclk_prev) begin
      edges++;
      if (hp_have) begin
        hp_d = cyc - last_tog;
        if (hp_d < hp_min) hp_min = hp_d;
        if (hp_d > hp_max) hp_max = hp_d;
      end
      hp_have = 1;
      last_tog = cyc;
    end
    sclk_prev = sclk;
    if (done === 1'b1) dones++;
    if (cs_n !== 5'h1f) cs_low++;
    cs_acc = cs_acc & cs_n;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    edges = 0;
    dones = 0;
    cs_low = 0;
    hp_have = 0;
    hp_min = 1000;
    hp_max = 0;
    cs_acc = '1;
  endtask

  // one frame; nc = edges from accept through ready
  task automatic run(input logic [7:0] d, input logic [3:0] l,
                     input logic [7:0] m, input logic p,
                     input logic h, input logic [2:0] s,
                     input bit poke, output int nc);
    @(negedge clk);
    din = d; len = l; cmax = m;
    cpol = p; cpha = h; sel = s;
    @(negedge clk);
    @(negedge clk);
    clr();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    nc = 1;
    while (!ready && nc < 3000) begin
      @(posedge clk);
      #1;
      nc++;
      if (poke && nc == 4) start = 1;
      if (poke && nc == 6) start = 0;
    end
    chk("ready_back", ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_sclk", sclk, p);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_cs", cs_n, 5'h1f);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_dout", dout, 0);
    @(negedge clk);
    rst_n = 1;

    loop = 1;
    run(8'hA5, 8, 0, 0, 0, 0, 0, n);
    chk("t1_data", dout, 8'hA5);
    chk("t1_edges", edges, 16);
    chk("t1_done", dones, 1);
    chk("t1_cycles", n, 20);
    chk("t1_cslow", cs_low, 18);
    chk("t1_csmask", cs_acc, 5'h1e);

    loop = 0;
    for (int m = 0; m < 4; m++) begin
      run(8'h96, 8, 1, m[1], m[0], 0, 0, n);
      chk("t2_data", dout, 8'h3C);
      chk("t2_slave_rx", s_rx, 8'h96);
      chk("t2_edges", edges, 16);
      chk("t2_cycles", n, 39);
    end

    loop = 1;
    run(8'hFF, 3, 0, 0, 0, 0, 0, n);
    chk("t3_len3_data", dout, 8'h07);
    chk("t3_len3_edges", edges, 6);
    chk("t3_len3_cycles", n, 10);
    run(8'hC3, 0, 0, 0, 0, 0, 0, n);
    chk("t3_len0_data", dout, 8'hC3);
    chk("t3_len0_edges", edges, 16);
    run(8'h5A, 12, 0, 1, 1, 0, 0, n);
    chk("t3_len12_data", dout, 8'h5A);
    chk("t3_len12_edges", edges, 16);

    run(8'h3C, 8, 4, 0, 0, 0, 0, n);
    chk("t4_hp_min", hp_min, 5);
    chk("t4_hp_max", hp_max, 5);
    chk("t4_cslow", cs_low, 90);
    chk("t4_cycles", n, 96);
    chk("t4_data", dout, 8'h3C);

    @(negedge clk);
    din = 8'h81; len = 8; cmax = 0;
    cpol = 0; cpha = 0; sel = 0;
    @(negedge clk);
    @(negedge clk);
    clr();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    w = 0;
    while (edges < 5 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("t5_edges", edges, 5);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("t5_cs", cs_n, 5'h1f);
    chk("t5_ready", ready, 1);
    chk("t5_sclk", sclk, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("t5_nodone", dones, 0);
    chk("t5_dout", dout, 0);

    run(8'hA5, 8, 0, 0, 0, 2, 1, n);
    chk("t6_sel2_mask", cs_acc, 5'b11011);
    chk("t6_busy_done", dones, 1);
    chk("t6_busy_cycles", n, 20);
    chk("t6_sel2_data", dout, 8'hA5);
    run(8'h5A, 8, 0, 0, 0, 5, 0, n);
    chk("t6_sel5_mask", cs_acc, 5'h1f);
    chk("t6_sel5_data", dout, 8'h5A);
    chk("t6_sel5_done", dones, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
